// File: rtl/booth_arith_pkg.sv
// Shared definitions for the arithmetic unit's sequential divider.
//   state_e : divider FSM states.
//   ABS_W   : working width of abs_u; operand widths must stay below it.
//   abs_u   : two's-complement to magnitude conversion. The result is unsigned,
//             so the magnitude of the most negative value fits.
package booth_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int ABS_W = 64;

  // The caller sign-extends the operand to ABS_W and truncates the result
  // back to the operand width.
  function automatic logic [ABS_W-1:0] abs_u(input logic signed [ABS_W-1:0] v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// One radix-2 non-restoring division step (purely combinational).
//   pr_i : (n+1)-bit two's-complement partial remainder
//   q_i  : n-bit quotient/dividend shift register
//   d_i  : n-bit divisor magnitude
//   pr_o : next partial remainder
//   q_o  : next quotient register (new bit shifted in at the LSB)
module nr_div_step #(
  parameter int n = 16
) (
  input  logic [n:0]   pr_i,
  input  logic [n-1:0] q_i,
  input  logic [n-1:0] d_i,
  output logic [n:0]   pr_o,
  output logic [n-1:0] q_o
);

  logic [n:0] pr_sh;

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first); a path that leaves one unassigned infers a latch.
  always_comb begin
    pr_sh = {pr_i[n-1:0], q_i[n-1]};
    pr_o  = pr_sh;
    // The sign of the unshifted remainder decides the operation. Doubling
    // cannot change the sign because |PR| < |D| <= 2^(n-1).
    if (!pr_i[n]) pr_o = pr_sh - {1'b0, d_i};
    else          pr_o = pr_sh + {1'b0, d_i};
    q_o = {q_i[n-2:0], ~pr_o[n]};
  end

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed divider, truncating semantics (same as SV '/' and '%').
// Radix-2 non-restoring, one quotient bit per clock.
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (Dividend, Divisor)
//   out_valid / out_ready : result handshake (Quotient, Remainder, flags)
//   DivByZero             : Divisor was 0 (Quotient = -1, Remainder = Dividend)
//   Overflow              : -2^(n-1) / -1 (Quotient wraps to -2^(n-1))
// Timing, counting the accepting edge as edge 1: out_valid is high after
// edge n+2 for a normal operation (1 accept + n CALC + 1 FIX). For a zero
// divisor it is high after the accepting edge itself.
module booth_seq_divider
  import booth_arith_pkg::*;
#(
  parameter int n = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [n-1:0] Dividend,
  input  logic signed [n-1:0] Divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [n-1:0] Quotient,
  output logic signed [n-1:0] Remainder,
  output logic                DivByZero,
  output logic                Overflow
);

  localparam int CW = $clog2(n);

  state_e         state_q;
  logic [n:0]     pr_q;
  logic [n-1:0]   q_q;
  logic [n-1:0]   d_q;
  logic [CW-1:0]  cnt_q;
  logic           neg_quot_q;
  logic           neg_rem_q;
  logic           ovf_pend_q;

  logic           in_ready_q;
  logic           out_valid_q;
  logic [n-1:0]   quot_q;
  logic [n-1:0]   rem_q;
  logic           dbz_q;
  logic           ovf_q;

  logic [n-1:0]   dvd_mag;
  logic [n-1:0]   dsr_mag;
  logic           ovf_case;
  logic [n:0]     pr_d;
  logic [n-1:0]   q_d;
  logic [n-1:0]   rem_mag_d;

  assign dvd_mag  = n'(abs_u(ABS_W'(Dividend)));
  assign dsr_mag  = n'(abs_u(ABS_W'(Divisor)));
  assign ovf_case = (Dividend == {1'b1, {(n-1){1'b0}}}) && (Divisor == '1);

  nr_div_step #(.n(n)) u_step (
    .pr_i (pr_q),
    .q_i  (q_q),
    .d_i  (d_q),
    .pr_o (pr_d),
    .q_o  (q_d)
  );

  // Final restoration: a negative remainder gets |D| added back. The true
  // remainder lies in [0, |D|), so n bits of the sum are exact.
  assign rem_mag_d = pr_q[n] ? (pr_q[n-1:0] + d_q) : pr_q[n-1:0];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pr_q        <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      ovf_pend_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            if (Divisor == '0) begin
              // Zero divisor: skip the iteration and report immediately.
              quot_q      <= '1;
              rem_q       <= Dividend;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              pr_q       <= '0;
              q_q        <= dvd_mag;
              d_q        <= dsr_mag;
              cnt_q      <= CW'(n - 1);
              neg_quot_q <= Dividend[n-1] ^ Divisor[n-1];
              neg_rem_q  <= Dividend[n-1];
              ovf_pend_q <= ovf_case;
              state_q    <= CALC;
            end
          end
        end
        CALC: begin
          pr_q <= pr_d;
          q_q  <= q_d;
          // The step taken while the counter reads 0 is the n-th one.
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        FIX: begin
          quot_q      <= neg_quot_q ? -q_q : q_q;
          rem_q       <= neg_rem_q ? -rem_mag_d : rem_mag_d;
          ovf_q       <= ovf_pend_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed and random checks for booth_seq_divider at n = 16.
// Latency is counted with the accepting edge as edge 1.
module tb_booth_seq_divider;

  localparam int N = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] Dividend;
  logic signed [N-1:0] Divisor;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] Quotient;
  logic signed [N-1:0] Remainder;
  logic                DivByZero;
  logic                Overflow;

  int n_cmp = 0;
  int n_bad = 0;

  booth_seq_divider #(.n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete operation. 'stall' cycles of out_ready=0 are held in DONE;
  // with 'poke' set, a competing operation is offered during the stall.
  task automatic run_op(input string tag,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edbz, input logic eovf,
                        input int elat, input int stall, input logic poke);
    int k;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, ".ready"}, 16'(in_ready), 16'd1);
    Dividend = a;
    Divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, ".lat"}, 16'(k), 16'(elat));
    check({tag, ".q"}, Quotient, eq);
    check({tag, ".r"}, Remainder, er);
    check({tag, ".flags"}, {14'd0, DivByZero, Overflow}, {14'd0, edbz, eovf});
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        Dividend = 16'd1234;
        Divisor  = 16'd3;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      check({tag, ".hold_q"}, Quotient, eq);
      check({tag, ".hold_r"}, Remainder, er);
      check({tag, ".hold_hs"}, {14'd0, out_valid, in_ready}, 16'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".handoff"}, {14'd0, out_valid, in_ready}, 16'b01);
  endtask

  initial begin
    logic [15:0] ra, rb, req, rer;
    int ai, bi, seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Dividend  = '0;
    Divisor   = '0;
    #12;
    check("rst.hs", {14'd0, out_valid, in_ready}, 16'b01);
    check("rst.q", Quotient, 16'd0);
    check("rst.r", Remainder, 16'd0);
    check("rst.flags", {14'd0, DivByZero, Overflow}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Sign combinations.
    run_op("p_p",    16'd100,    16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 18, 0, 1'b0);
    run_op("n_p",    -16'sd100,  16'd7,      -16'sd14,   -16'sd2,    1'b0, 1'b0, 18, 0, 1'b0);
    run_op("p_n",    16'd100,    -16'sd7,    -16'sd14,   16'd2,      1'b0, 1'b0, 18, 0, 1'b0);
    run_op("n_n",    -16'sd100,  -16'sd7,    16'd14,     -16'sd2,    1'b0, 1'b0, 18, 0, 1'b0);
    // Most-negative dividend.
    run_op("ovf",    16'h8000,   16'hFFFF,   16'h8000,   16'd0,      1'b0, 1'b1, 18, 0, 1'b0);
    run_op("min_1",  16'h8000,   16'd1,      16'h8000,   16'd0,      1'b0, 1'b0, 18, 0, 1'b0);
    run_op("max_min",16'h7FFF,   16'h8000,   16'd0,      16'h7FFF,   1'b0, 1'b0, 18, 0, 1'b0);
    // Zero divisor, then back-pressure with a competing request.
    run_op("dbz",    16'd5,      16'd0,      16'hFFFF,   16'd5,      1'b1, 1'b0, 1,  0, 1'b0);
    run_op("bp",     16'd1000,   -16'sd9,    -16'sd111,  16'd1,      1'b0, 1'b0, 18, 3, 1'b1);
    run_op("dbz2",   -16'sd3,    16'd0,      16'hFFFF,   16'hFFFD,   1'b1, 1'b0, 1,  0, 1'b0);

    // Reset five cycles into CALC; outputs still hold the dbz2 result.
    Dividend = 16'd100;
    Divisor  = 16'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst.hs", {14'd0, out_valid, in_ready}, 16'b01);
    check("mid_rst.q", Quotient, 16'd0);
    check("mid_rst.r", Remainder, 16'd0);
    check("mid_rst.flags", {14'd0, DivByZero, Overflow}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mid_rst.no_result", 16'(seen), 16'd0);
    run_op("after_rst", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0, 18, 0, 1'b0);

    // Random pairs against the language's own signed division.
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 4))
        0: rb = 16'($urandom_range(0, 15));
        1: rb = -16'($urandom_range(0, 15));
        2: ra = 16'h8000;
        3: rb = 16'h8000;
        default: ;
      endcase
      ai = int'($signed(ra));
      bi = int'($signed(rb));
      if (bi == 0) begin
        req = 16'hFFFF;
        rer = ra;
      end else begin
        req = 16'(ai / bi);
        rer = 16'(ai % bi);
      end
      run_op("rnd", ra, rb, req, rer, (bi == 0),
             (ra == 16'h8000 && rb == 16'hFFFF),
             (bi == 0) ? 1 : 18, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
